// File: rtl/ahb_to_dsram_bridge_if.sv
// AHB-Lite bus bundle between an AHB master/interconnect and the data-SRAM bridge.
interface ahb_to_dsram_bridge_if #(
  parameter int AW = 18
);
  logic          HSEL;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_to_dsram_bridge.sv
// Zero-wait AHB-Lite slave driving the data SRAM; a one-entry write buffer absorbs write/read collisions.
// Optional alignment checking with two-cycle ERROR responses is enabled by defining DSRAM_ALIGN_CHECK_EN.
module ahb_to_dsram_bridge #(
  parameter int AW = 18
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  ahb_to_dsram_bridge_if.slave ahb,
  output logic [AW-3:0]        SRAMADDR,
  output logic [31:0]          SRAMWDATA,
  output logic [3:0]           SRAMWEN,
  output logic                 SRAMCS,
  input  logic [31:0]          SRAMRDATA
);

  logic          acc_raw;
  logic          acc;
  logic          rd_ap;
  logic          wr_ap;
  logic [AW-3:0] ap_addr;
  logic [3:0]    ap_mask;

  logic          wr_dph;
  logic          rd_dph;
  logic [AW-3:0] dph_addr;
  logic [3:0]    dph_mask;

  logic          buf_pend;
  logic [AW-3:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;

  logic          sram_cs;
  logic [3:0]    sram_wen;
  logic [31:0]   rdata_merged;

  logic          unused_htrans0;
  assign unused_htrans0 = ahb.HTRANS[0];

  assign acc_raw = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
  assign ap_addr = ahb.HADDR[AW-1:2];
  assign rd_ap   = acc & ~ahb.HWRITE;
  assign wr_ap   = acc & ahb.HWRITE;

  always_comb begin
    case (ahb.HSIZE)
      3'd0:    ap_mask = 4'b0001 << ahb.HADDR[1:0];
      3'd1:    ap_mask = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
      default: ap_mask = 4'b1111;
    endcase
  end

`ifdef DSRAM_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_FIRST,
    ERR_SECOND
  } err_state_t;

  err_state_t err_state;
  logic       misalign;
  logic       hreadyout_q;
  logic       hresp_q;

  always_comb begin
    misalign = (ahb.HSIZE > 3'd2)
             | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
             | ((ahb.HSIZE == 3'd2) & (|ahb.HADDR[1:0]));
  end

  assign acc = acc_raw & ~misalign;

  // HREADY is low during ERR_FIRST, so only ERR_NONE/ERR_SECOND can see a new address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_state   <= ERR_NONE;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      case (err_state)
        ERR_FIRST: begin
          err_state   <= ERR_SECOND;
          hreadyout_q <= 1'b1;
          hresp_q     <= 1'b1;
        end
        default: begin
          if (acc_raw & misalign) begin
            err_state   <= ERR_FIRST;
            hreadyout_q <= 1'b0;
            hresp_q     <= 1'b1;
          end else begin
            err_state   <= ERR_NONE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ahb.HREADYOUT = hreadyout_q;
  assign ahb.HRESP     = hresp_q;
`else
  assign acc           = acc_raw;
  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_dph   <= 1'b0;
      rd_dph   <= 1'b0;
      dph_addr <= '0;
      dph_mask <= '0;
    end else if (ahb.HREADY) begin
      wr_dph   <= wr_ap;
      rd_dph   <= rd_ap;
      dph_addr <= ap_addr;
      dph_mask <= ap_mask;
    end
  end

  // A write's own address phase is never a read, so the buffer is always empty when a new write is captured.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      buf_pend <= 1'b0;
      buf_addr <= '0;
      buf_mask <= '0;
      buf_data <= '0;
    end else if (wr_dph & rd_ap) begin
      buf_pend <= 1'b1;
      buf_addr <= dph_addr;
      buf_mask <= dph_mask;
      buf_data <= ahb.HWDATA;
    end else if (!rd_ap && !wr_dph) begin
      buf_pend <= 1'b0;
    end
  end

  always_comb begin
    sram_cs   = 1'b0;
    sram_wen  = '0;
    SRAMADDR  = ap_addr;
    SRAMWDATA = ahb.HWDATA;
    if (rd_ap) begin
      sram_cs  = 1'b1;
    end else if (wr_dph) begin
      sram_cs  = 1'b1;
      SRAMADDR = dph_addr;
      sram_wen = dph_mask;
    end else if (buf_pend) begin
      sram_cs   = 1'b1;
      SRAMADDR  = buf_addr;
      SRAMWDATA = buf_data;
      sram_wen  = buf_mask;
    end
  end

  assign SRAMCS  = sram_cs & HRESETn;
  assign SRAMWEN = sram_wen & {4{HRESETn}};

  always_comb begin
    rdata_merged = SRAMRDATA;
    if (buf_pend && (buf_addr == dph_addr)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (buf_mask[i]) rdata_merged[8*i +: 8] = buf_data[8*i +: 8];
      end
    end
  end

  assign ahb.HRDATA = rd_dph ? rdata_merged : '0;

endmodule

// File: tb/tb_ahb_to_dsram_bridge.sv
// Directed bench for ahb_to_dsram_bridge with a behavioural registered-read data SRAM.
module tb_ahb_to_dsram_bridge;

  logic        HCLK;
  logic        HRESETn;
  logic [15:0] SRAMADDR;
  logic [31:0] SRAMWDATA;
  logic [3:0]  SRAMWEN;
  logic        SRAMCS;
  logic [31:0] SRAMRDATA;

  logic [31:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  ahb_to_dsram_bridge_if #(.AW(18)) bus ();

  ahb_to_dsram_bridge #(.AW(18)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .ahb      (bus),
    .SRAMADDR (SRAMADDR),
    .SRAMWDATA(SRAMWDATA),
    .SRAMWEN  (SRAMWEN),
    .SRAMCS   (SRAMCS),
    .SRAMRDATA(SRAMRDATA)
  );

  // Single slave on the bus: the interconnect's HREADY is this slave's HREADYOUT.
  assign bus.HREADY = bus.HREADYOUT;

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = '0;
  end

  always @(posedge HCLK) begin
    if (SRAMCS) begin
      for (int b = 0; b < 4; b++) begin
        if (SRAMWEN[b]) mem[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
      end
      SRAMRDATA <= mem[SRAMADDR];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic w, input logic [17:0] a,
                       input logic [2:0] s, input logic [31:0] wd);
    bus.HSEL   = v;
    bus.HTRANS = v ? 2'b10 : 2'b00;
    bus.HWRITE = w;
    bus.HADDR  = a;
    bus.HSIZE  = s;
    bus.HWDATA = wd;
  endtask

  task automatic idle(input logic [31:0] wd);
    drive(1'b0, 1'b0, 18'h0, 3'd2, wd);
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  initial begin
    HRESETn   = 1'b0;
    SRAMRDATA = '0;
    idle(32'h0);

    @(negedge HCLK);
    check("rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    check("rst_hresp",     {31'b0, bus.HRESP},     32'h0);
    check("rst_hrdata",    bus.HRDATA,             32'h0);
    check("rst_sramcs",    {31'b0, SRAMCS},        32'h0);
    check("rst_sramwen",   {28'b0, SRAMWEN},       32'h0);
    #2 HRESETn = 1'b1;
    tick();

    // 1: write, idle, read back through SRAM
    drive(1'b1, 1'b1, 18'h100, 3'd2, 32'h0);
    @(negedge HCLK);
    check("t1_ap_cs", {31'b0, SRAMCS}, 32'h0);
    tick();
    idle(32'hDEADBEEF);
    @(negedge HCLK);
    check("t1_wen",   {28'b0, SRAMWEN}, 32'hF);
    check("t1_waddr", {16'b0, SRAMADDR}, 32'h40);
    check("t1_wdata", SRAMWDATA, 32'hDEADBEEF);
    tick();
    drive(1'b1, 1'b0, 18'h100, 3'd2, 32'h0);
    @(negedge HCLK);
    check("t1_rd_cs",   {31'b0, SRAMCS}, 32'h1);
    check("t1_rd_wen",  {28'b0, SRAMWEN}, 32'h0);
    check("t1_rd_addr", {16'b0, SRAMADDR}, 32'h40);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t1_hrdata",    bus.HRDATA, 32'hDEADBEEF);
    check("t1_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    tick();

    // 2: write immediately followed by read of the same word
    drive(1'b1, 1'b1, 18'h200, 3'd2, 32'h0);
    tick();
    drive(1'b1, 1'b0, 18'h200, 3'd2, 32'h11223344);
    @(negedge HCLK);
    check("t2_rd_wen",  {28'b0, SRAMWEN}, 32'h0);
    check("t2_rd_addr", {16'b0, SRAMADDR}, 32'h80);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t2_hrdata_merge", bus.HRDATA, 32'h11223344);
    check("t2_drain_wen",    {28'b0, SRAMWEN}, 32'hF);
    check("t2_drain_addr",   {16'b0, SRAMADDR}, 32'h80);
    check("t2_drain_data",   SRAMWDATA, 32'h11223344);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t2_after_cs", {31'b0, SRAMCS}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 18'h200, 3'd2, 32'h0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t2_sram_rd", bus.HRDATA, 32'h11223344);
    tick();

    // 3: word write, byte write, read with byte merge
    drive(1'b1, 1'b1, 18'h300, 3'd2, 32'h0);
    tick();
    drive(1'b1, 1'b1, 18'h302, 3'd0, 32'hAABBCCDD);
    @(negedge HCLK);
    check("t3_word_wen", {28'b0, SRAMWEN}, 32'hF);
    tick();
    drive(1'b1, 1'b0, 18'h300, 3'd2, 32'h00550000);
    @(negedge HCLK);
    check("t3_rd_wen", {28'b0, SRAMWEN}, 32'h0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t3_hrdata",  bus.HRDATA, 32'hAA55CCDD);
    check("t3_byte_wen", {28'b0, SRAMWEN}, 32'h4);
    tick();

    // 4: buffer held across back-to-back reads, merge only on the matching word
    drive(1'b1, 1'b1, 18'h400, 3'd2, 32'h0);
    tick();
    drive(1'b1, 1'b0, 18'h404, 3'd2, 32'hCAFEF00D);
    @(negedge HCLK);
    check("t4_rd1_wen", {28'b0, SRAMWEN}, 32'h0);
    check("t4_rd1_addr", {16'b0, SRAMADDR}, 32'h101);
    tick();
    drive(1'b1, 1'b0, 18'h400, 3'd2, 32'h0);
    @(negedge HCLK);
    check("t4_rd2_wen",  {28'b0, SRAMWEN}, 32'h0);
    check("t4_rd2_addr", {16'b0, SRAMADDR}, 32'h100);
    check("t4_rd1_data", bus.HRDATA, 32'h0);
    tick();
    drive(1'b1, 1'b0, 18'h404, 3'd2, 32'h0);
    @(negedge HCLK);
    check("t4_rd3_wen",  {28'b0, SRAMWEN}, 32'h0);
    check("t4_rd2_data", bus.HRDATA, 32'hCAFEF00D);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t4_rd3_data",   bus.HRDATA, 32'h0);
    check("t4_drain_wen",  {28'b0, SRAMWEN}, 32'hF);
    check("t4_drain_addr", {16'b0, SRAMADDR}, 32'h100);
    check("t4_drain_data", SRAMWDATA, 32'hCAFEF00D);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t4_after_cs", {31'b0, SRAMCS}, 32'h0);
    tick();

    // 5: reset while a buffered write is pending
    drive(1'b1, 1'b1, 18'h500, 3'd2, 32'h0);
    tick();
    drive(1'b1, 1'b0, 18'h504, 3'd2, 32'h12345678);
    @(negedge HCLK);
    check("t5_buffered_wen", {28'b0, SRAMWEN}, 32'h0);
    tick();
    HRESETn = 1'b0;
    idle(32'h0);
    @(negedge HCLK);
    check("t5_rst_wen",       {28'b0, SRAMWEN}, 32'h0);
    check("t5_rst_cs",        {31'b0, SRAMCS}, 32'h0);
    check("t5_rst_hreadyout", {31'b0, bus.HREADYOUT}, 32'h1);
    check("t5_rst_hrdata",    bus.HRDATA, 32'h0);
    tick();
    @(negedge HCLK);
    HRESETn = 1'b1;
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t5_post_cs", {31'b0, SRAMCS}, 32'h0);
    tick();
    drive(1'b1, 1'b0, 18'h500, 3'd2, 32'h0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t5_not_written", bus.HRDATA, 32'h0);
    tick();

    // 6: misaligned word read
`ifdef DSRAM_ALIGN_CHECK_EN
    drive(1'b1, 1'b0, 18'h102, 3'd2, 32'h0);
    @(negedge HCLK);
    check("t6_cs", {31'b0, SRAMCS}, 32'h0);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t6_err1_ready", {31'b0, bus.HREADYOUT}, 32'h0);
    check("t6_err1_resp",  {31'b0, bus.HRESP}, 32'h1);
    check("t6_err1_cs",    {31'b0, SRAMCS}, 32'h0);
    tick();
    @(negedge HCLK);
    check("t6_err2_ready", {31'b0, bus.HREADYOUT}, 32'h1);
    check("t6_err2_resp",  {31'b0, bus.HRESP}, 32'h1);
    check("t6_err2_rdata", bus.HRDATA, 32'h0);
    tick();
    @(negedge HCLK);
    check("t6_ok_resp", {31'b0, bus.HRESP}, 32'h0);
    tick();
`else
    drive(1'b1, 1'b0, 18'h102, 3'd2, 32'h0);
    @(negedge HCLK);
    check("t6_cs",   {31'b0, SRAMCS}, 32'h1);
    check("t6_addr", {16'b0, SRAMADDR}, 32'h40);
    tick();
    idle(32'h0);
    @(negedge HCLK);
    check("t6_hrdata", bus.HRDATA, 32'hDEADBEEF);
    check("t6_hresp",  {31'b0, bus.HRESP}, 32'h0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
